mc_main_fsm: RTL and testbench

MC_MAIN_FSM -- requirements
Module: mc_main_fsm

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_alu_decoder.sv | 41 ++++
 rtl/mc_main_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_mc_main_fsm.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle RISC-V control FSM: state codes, opcodes
// and the datapath select/ALU encodings driven by mc_main_fsm.
package mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNC   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALUControl decode from the instruction's func fields and the
// FSM's ALU operation class.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic [1:0] aluop,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_BRANCH: begin
                case (func3[2:1])
                    2'b00:   alu_control = ALU_SUB;
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUOP_FUNC: begin
                case (func3)
                    // func7[5] selects sub only for register-register ops; for addi it is immediate bits
                    3'b000:  alu_control = (op5 && func7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = func7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle RISC-V main control FSM with unified-memory handshake and wait trap.
// Define PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_main_fsm
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IrWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       ALUControl,
    output logic             halted
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    logic [3:0]  state;
    logic [3:0]  next_state;
    logic [31:0] wait_cnt;
    logic        link_wb;
    logic        wait_expired;
    logic        branch_taken;
    logic [1:0]  aluop;
    logic        unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};
    assign wait_expired = (MEM_WAIT_MAX != 0) && (wait_cnt == MEM_WAIT_MAX - 1);

    mc_alu_decoder u_alu_decoder (
        .op5        (op[5]),
        .func3      (func3),
        .func7_5    (func7[5]),
        .aluop      (aluop),
        .alu_control(ALUControl)
    );

    always_comb begin
        case (func3)
            3'b000:         branch_taken = zero;
            3'b001:         branch_taken = !zero;
            3'b100, 3'b110: branch_taken = !zero;
            3'b101, 3'b111: branch_taken = zero;
            default:        branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)         next_state = S_DECODE;
                else if (wait_expired) next_state = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR:  next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)         next_state = S_MEMWB;
                else if (wait_expired) next_state = S_TRAP;
            end
            S_MEMWRITE: begin
                if (mem_ready)         next_state = S_FETCH;
                else if (wait_expired) next_state = S_TRAP;
            end
            S_MEMWB, S_ALUWB:                       next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI: next_state = S_ALUWB;
            S_BRANCH: next_state = (func3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_TRAP;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IrWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        aluop     = ALUOP_ADD;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // mem_ready is combinational; gating with rst_n keeps enables off during reset
                IrWrite   = mem_ready && rst_n;
                PCWrite   = mem_ready && rst_n;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = mem_ready;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_DATA;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_FUNC;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNC;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                // jumps write the link address OldPC+4 instead of the latched ALUOut
                if (link_wb) begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_BRANCH;
                PCWrite = branch_taken;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_J;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
            end
            S_TRAP:  halted = 1'b1;
            default: halted = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            link_wb  <= 1'b0;
        end else begin
            state    <= next_state;
            link_wb  <= (state == S_JAL) || (state == S_JALR);
            wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 32'd1 : '0;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_TRAP)
                cycle_cnt <= cycle_cnt + 1'b1;
            if ((next_state == S_FETCH) && (state != S_FETCH))
                instr_cnt <= instr_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm: per-cycle control signature checks against
// hand-derived vectors; counter checks apply when PERF_CNT_EN is defined.
module tb_mc_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IrWrite, RegWrite, halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
`ifdef PERF_CNT_EN
    logic [3:0] cycle_cnt, instr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mc_main_fsm #(.CNT_W(4), .MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IrWrite(IrWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .halted(halted)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    // {mem_req,PCWrite,AdrSrc,MemWrite,IrWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,halted}
    logic [19:0] sig;
    assign sig = {mem_req, PCWrite, AdrSrc, MemWrite, IrWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted};

    localparam logic [19:0] F_RDY   = {6'b110010, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0};
    localparam logic [19:0] F_WAIT  = {6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0};
    localparam logic [19:0] DEC     = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000, 1'b0};
    localparam logic [19:0] WB_R    = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
    localparam logic [19:0] WB_LINK = {6'b000001, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0};
    localparam logic [19:0] TRAPPED = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1};
    localparam logic [19:0] MRD     = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};

    function automatic logic [19:0] mk(input logic mreq, pcw, adr, mw, irw, rw,
                                       input logic [1:0] res, srca, srcb,
                                       input logic [2:0] imm, input logic [3:0] aluc);
        return {mreq, pcw, adr, mw, irw, rw, res, srca, srcb, imm, aluc, 1'b0};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [19:0] exp);
        #1;
        check(tag, 32'(sig), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o; func3 = f3; func7 = f7;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #2;
        check({tag, ".sig"}, 32'(sig), 32'(F_WAIT));
`ifdef PERF_CNT_EN
        check({tag, ".cyc"}, 32'(cycle_cnt), 32'd0);
        check({tag, ".ins"}, 32'(instr_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic r_type(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [3:0] aluc);
        set_instr(7'b0110011, f3, f7);
        mem_ready = 1'b1;
        step({tag, ".fetch"}, F_RDY);
        step({tag, ".dec"}, DEC);
        step({tag, ".exec"}, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, aluc));
        step({tag, ".wb"}, WB_R);
    endtask

    task automatic i_type(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [3:0] aluc);
        set_instr(7'b0010011, f3, f7);
        mem_ready = 1'b1;
        step({tag, ".fetch"}, F_RDY);
        step({tag, ".dec"}, DEC);
        step({tag, ".exec"}, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, aluc));
        step({tag, ".wb"}, WB_R);
    endtask

    task automatic branch(input string tag, input logic [2:0] f3, input logic z,
                          input logic pcw, input logic [3:0] aluc);
        set_instr(7'b1100011, f3, 7'd0);
        mem_ready = 1'b1;
        zero = z;
        step({tag, ".fetch"}, F_RDY);
        step({tag, ".dec"}, DEC);
        step({tag, ".br"}, mk(0, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, aluc));
    endtask

    initial begin
        rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        set_instr(7'd0, 3'd0, 7'd0);
        do_reset("reset");

        r_type("add", 3'b000, 7'b0000000, 4'b0000);
`ifdef PERF_CNT_EN
        check("perf.cyc4", 32'(cycle_cnt), 32'd4);
        check("perf.ins1", 32'(instr_cnt), 32'd1);
`endif
        for (int i = 0; i < 3; i++) r_type("addn", 3'b000, 7'b0000000, 4'b0000);
`ifdef PERF_CNT_EN
        check("perf.cycwrap", 32'(cycle_cnt), 32'd0);
        check("perf.ins4", 32'(instr_cnt), 32'd4);
`endif

        r_type("sub", 3'b000, 7'b0100000, 4'b0001);
        r_type("and", 3'b111, 7'b0000000, 4'b0010);
        r_type("sra", 3'b101, 7'b0100000, 4'b1001);
        i_type("addi_neg", 3'b000, 7'b1111111, 4'b0000);
        i_type("srai", 3'b101, 7'b0100000, 4'b1001);
        i_type("sltiu", 3'b011, 7'b0000000, 4'b0110);

        // lw: three wait cycles in MEMREAD, completes on cycle 8
        set_instr(7'b0000011, 3'b010, 7'd0);
        mem_ready = 1'b1;
        step("lw.fetch", F_RDY);
        mem_ready = 1'b1;
        step("lw.dec_ready_ignored", DEC);
        mem_ready = 1'b0;
        step("lw.adr", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000));
        for (int i = 0; i < 3; i++) step("lw.wait", MRD);
        mem_ready = 1'b1;
        step("lw.read", MRD);
        step("lw.wb", mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000));

        set_instr(7'b0100011, 3'b010, 7'd0);
        step("sw.fetch", F_RDY);
        step("sw.dec", DEC);
        mem_ready = 1'b0;
        step("sw.adr", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000));
        step("sw.wait", mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000));
        mem_ready = 1'b1;
        step("sw.write", mk(1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000));

        branch("bne_nz", 3'b001, 1'b0, 1'b1, 4'b0001);
        branch("beq_nz", 3'b000, 1'b0, 1'b0, 4'b0001);
        branch("beq_z", 3'b000, 1'b1, 1'b1, 4'b0001);
        branch("blt_nz", 3'b100, 1'b0, 1'b1, 4'b0101);
        branch("bgeu_nz", 3'b111, 1'b0, 1'b0, 4'b0110);
        zero = 1'b0;

        set_instr(7'b1101111, 3'b000, 7'd0);
        step("jal.fetch", F_RDY);
        step("jal.dec", DEC);
        step("jal.jump", mk(0, 1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 3'b011, 4'b0000));
        step("jal.wb", WB_LINK);

        set_instr(7'b1100111, 3'b000, 7'd0);
        step("jalr.fetch", F_RDY);
        step("jalr.dec", DEC);
        step("jalr.jump", mk(0, 1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 4'b0000));
        step("jalr.wb", WB_LINK);

        set_instr(7'b0110111, 3'b000, 7'd0);
        step("lui.fetch", F_RDY);
        step("lui.dec", DEC);
        step("lui.imm", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b100, 4'b0000));
        step("lui.wb", WB_R);

        // reset in the middle of a load read aborts it
        set_instr(7'b0000011, 3'b010, 7'd0);
        step("abort.fetch", F_RDY);
        step("abort.dec", DEC);
        mem_ready = 1'b0;
        step("abort.adr", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000));
        step("abort.wait", MRD);
        do_reset("abort.rst");
        mem_ready = 1'b0;
        step("abort.refetch_wait", F_WAIT);
        set_instr(7'b0110011, 3'b000, 7'd0);
        r_type("abort.add", 3'b000, 7'd0, 4'b0000);

        set_instr(7'b0000000, 3'b000, 7'd0);
        step("ill.fetch", F_RDY);
        step("ill.dec", DEC);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step("ill.hold", TRAPPED);
        end
        do_reset("ill.rst");
        step("ill.after_rst", F_RDY);

        set_instr(7'b1100011, 3'b010, 7'd0);
        step("brill.dec", DEC);
        step("brill.br", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0000));
        step("brill.trap", TRAPPED);
        do_reset("brill.rst");

        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("tmo.wait", F_WAIT);
        mem_ready = 1'b1;
        step("tmo.trap", TRAPPED);
        step("tmo.hold", TRAPPED);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
